// File: rtl/ex_mem_stage.sv
// ---------------------------------------------------------------------------
// ex_mem_stage
//
// Execute-to-memory pipeline boundary. Evaluates the instruction's 4-bit
// condition field against the architectural status flags, owns those flags
// (updated from the ALU {N,Z,C,V} output), gates side effects on the
// condition result, and registers result/store data/control into MEM.
// A saturating counter records valid instructions squashed by a failed
// condition, for debug visibility.
//
// Ports:
//   clk, reset        clock (rising edge), synchronous active-high reset
//   stall             hold every register in this block
//   flush             replace the instruction in EX with a bubble
//   valid_e           EX holds a real instruction
//   cond_e            condition field
//   flag_w_e          [1] write N,Z   [0] write C,V
//   reg_w_e, mem_w_e, mem_to_reg_e, pc_src_e   EX control
//   alu_result_e      ALU result
//   alu_flags_e       ALU flags {N,Z,C,V}
//   write_data_e      store data
//   wa3_e             destination register
//   cond_ex_e         condition passed (combinational on cond_e/flags_q)
//   flags_q           architectural flags {N,Z,C,V}
//   valid_m, reg_w_m, mem_w_m, mem_to_reg_m, pc_src_m   MEM control
//   alu_result_m, write_data_m, wa3_m                   MEM data
//   squash_count      saturating count of condition-failed instructions
// ---------------------------------------------------------------------------
module ex_mem_stage #(
  parameter int RES_W = 30,
  parameter int REG_W = 19,
  parameter int RA_W  = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             valid_e,
  input  logic [3:0]       cond_e,
  input  logic [1:0]       flag_w_e,
  input  logic             reg_w_e,
  input  logic             mem_w_e,
  input  logic             mem_to_reg_e,
  input  logic             pc_src_e,
  input  logic [RES_W-1:0] alu_result_e,
  input  logic [3:0]       alu_flags_e,
  input  logic [REG_W-1:0] write_data_e,
  input  logic [RA_W-1:0]  wa3_e,
  output logic             cond_ex_e,
  output logic [3:0]       flags_q,
  output logic             valid_m,
  output logic             reg_w_m,
  output logic             mem_w_m,
  output logic             mem_to_reg_m,
  output logic             pc_src_m,
  output logic [RES_W-1:0] alu_result_m,
  output logic [REG_W-1:0] write_data_m,
  output logic [RA_W-1:0]  wa3_m,
  output logic [CNT_W-1:0] squash_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [3:0] {
    C_EQ = 4'h0, C_NE = 4'h1, C_CS = 4'h2, C_CC = 4'h3,
    C_MI = 4'h4, C_PL = 4'h5, C_VS = 4'h6, C_VC = 4'h7,
    C_HI = 4'h8, C_LS = 4'h9, C_GE = 4'hA, C_LT = 4'hB,
    C_GT = 4'hC, C_LE = 4'hD, C_AL = 4'hE, C_NV = 4'hF
  } cond_t;

  logic flag_n, flag_z, flag_c, flag_v;
  logic exec;
  logic squash;
  logic cnt_sat;

  assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

  // Condition check uses only the registered flags, so a flag-setting
  // instruction one slot ahead is already visible here without a bypass
  // from alu_flags_e.
  always_comb begin
    cond_ex_e = 1'b0;
    case (cond_t'(cond_e))
      C_EQ:    cond_ex_e = flag_z;
      C_NE:    cond_ex_e = ~flag_z;
      C_CS:    cond_ex_e = flag_c;
      C_CC:    cond_ex_e = ~flag_c;
      C_MI:    cond_ex_e = flag_n;
      C_PL:    cond_ex_e = ~flag_n;
      C_VS:    cond_ex_e = flag_v;
      C_VC:    cond_ex_e = ~flag_v;
      C_HI:    cond_ex_e = flag_c & ~flag_z;
      C_LS:    cond_ex_e = ~flag_c | flag_z;
      C_GE:    cond_ex_e = (flag_n == flag_v);
      C_LT:    cond_ex_e = (flag_n != flag_v);
      C_GT:    cond_ex_e = ~flag_z & (flag_n == flag_v);
      C_LE:    cond_ex_e = flag_z | (flag_n != flag_v);
      C_AL:    cond_ex_e = 1'b1;
      C_NV:    cond_ex_e = 1'b0;
      default: cond_ex_e = 1'b0;
    endcase
  end

  assign exec    = valid_e & cond_ex_e & ~flush;
  assign squash  = valid_e & ~cond_ex_e;
  assign cnt_sat = (squash_count == CNT_MAX);

  // MEM pipeline register. Data fields follow EX unconditionally; only the
  // control bits carry the side-effect gating.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      valid_m      <= 1'b0;
      reg_w_m      <= 1'b0;
      mem_w_m      <= 1'b0;
      mem_to_reg_m <= 1'b0;
      pc_src_m     <= 1'b0;
      alu_result_m <= '0;
      write_data_m <= '0;
      wa3_m        <= '0;
    end else if (!stall) begin
      valid_m      <= exec;
      reg_w_m      <= reg_w_e & exec;
      mem_w_m      <= mem_w_e & exec;
      mem_to_reg_m <= mem_to_reg_e & exec;
      pc_src_m     <= pc_src_e & exec;
      alu_result_m <= alu_result_e;
      write_data_m <= write_data_e;
      wa3_m        <= wa3_e;
    end
  end

  // Architectural flags: N,Z and C,V are independently write-enabled so
  // instructions that only define part of the flag set leave the rest alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= 4'b0000;
    end else if (!flush && !stall) begin
      if (exec && flag_w_e[1]) flags_q[3:2] <= alu_flags_e[3:2];
      if (exec && flag_w_e[0]) flags_q[1:0] <= alu_flags_e[1:0];
    end
  end

  // Squash counter saturates so a long-running debug capture never reads
  // back a misleadingly small value after wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      squash_count <= '0;
    end else if (!flush && !stall && squash && !cnt_sat) begin
      squash_count <= squash_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
module tb_ex_mem_stage;

  localparam int RES_W = 30;
  localparam int REG_W = 19;
  localparam int RA_W  = 4;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             stall = 1'b1;
  logic             flush = 1'b1;
  logic             valid_e = 1'b0;
  logic [3:0]       cond_e = 4'h0;
  logic [1:0]       flag_w_e = 2'b00;
  logic             reg_w_e = 1'b0;
  logic             mem_w_e = 1'b0;
  logic             mem_to_reg_e = 1'b0;
  logic             pc_src_e = 1'b0;
  logic [RES_W-1:0] alu_result_e = '0;
  logic [3:0]       alu_flags_e = 4'h0;
  logic [REG_W-1:0] write_data_e = '0;
  logic [RA_W-1:0]  wa3_e = '0;
  logic             cond_ex_e;
  logic [3:0]       flags_q;
  logic             valid_m, reg_w_m, mem_w_m, mem_to_reg_m, pc_src_m;
  logic [RES_W-1:0] alu_result_m;
  logic [REG_W-1:0] write_data_m;
  logic [RA_W-1:0]  wa3_m;
  logic [CNT_W-1:0] squash_count;

  ex_mem_stage #(.RES_W(RES_W), .REG_W(REG_W), .RA_W(RA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .valid_e(valid_e), .cond_e(cond_e), .flag_w_e(flag_w_e),
    .reg_w_e(reg_w_e), .mem_w_e(mem_w_e), .mem_to_reg_e(mem_to_reg_e),
    .pc_src_e(pc_src_e), .alu_result_e(alu_result_e), .alu_flags_e(alu_flags_e),
    .write_data_e(write_data_e), .wa3_e(wa3_e), .cond_ex_e(cond_ex_e),
    .flags_q(flags_q), .valid_m(valid_m), .reg_w_m(reg_w_m), .mem_w_m(mem_w_m),
    .mem_to_reg_m(mem_to_reg_m), .pc_src_m(pc_src_m), .alu_result_m(alu_result_m),
    .write_data_m(write_data_m), .wa3_m(wa3_m), .squash_count(squash_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               id;
    int               ec;      // expected cond_ex_e, -1 = not checked
    logic             chk;     // check registered state after the edge
    logic [3:0]       flags;
    logic             valid;
    logic             rw;
    logic             mw;
    logic [RES_W-1:0] res;
    logic [CNT_W-1:0] sq;
  } exp_t;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   vec_id     = 0;

  task automatic chk(input int id, input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL vec%0d %s: got %0h expected %0h", id, nm, act, req);
    end
  endtask

  // Stimulus: mem_to_reg_e mirrors mem_w_e, pc_src_e mirrors reg_w_e, and the
  // store data / destination are slices of the result, so their expected MEM
  // values follow from the hand-computed expectations below.
  task automatic step(input logic r, input logic st, input logic fl, input logic v,
                      input logic [3:0] c, input logic [1:0] fw, input logic [3:0] af,
                      input logic [RES_W-1:0] res, input logic rw, input logic mw,
                      input int ec, input logic ck, input logic [3:0] ef,
                      input logic ev, input logic erw, input logic emw,
                      input logic [RES_W-1:0] eres, input logic [CNT_W-1:0] esq);
    exp_t e;
    @(negedge clk);
    reset = r; stall = st; flush = fl; valid_e = v; cond_e = c; flag_w_e = fw;
    alu_flags_e = af; alu_result_e = res; reg_w_e = rw; mem_w_e = mw;
    mem_to_reg_e = mw; pc_src_e = rw;
    write_data_e = res[REG_W-1:0]; wa3_e = res[RA_W-1:0];
    e.id = vec_id; e.ec = ec; e.chk = ck; e.flags = ef; e.valid = ev;
    e.rw = erw; e.mw = emw; e.res = eres; e.sq = esq;
    vec_id++;
    exp_q.push_back(e);
    @(posedge clk);
  endtask

  // Monitor: pops one expectation per cycle; cond_ex_e checked once inputs
  // settle, registered outputs checked just after the following edge.
  initial begin
    exp_t cur;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        cur = exp_q.pop_front();
        if (cur.ec >= 0) chk(cur.id, "cond_ex_e", {31'd0, cond_ex_e}, cur.ec);
        @(posedge clk);
        #1;
        if (cur.chk) begin
          chk(cur.id, "flags_q",      {28'd0, flags_q},      {28'd0, cur.flags});
          chk(cur.id, "valid_m",      {31'd0, valid_m},      {31'd0, cur.valid});
          chk(cur.id, "reg_w_m",      {31'd0, reg_w_m},      {31'd0, cur.rw});
          chk(cur.id, "mem_w_m",      {31'd0, mem_w_m},      {31'd0, cur.mw});
          chk(cur.id, "mem_to_reg_m", {31'd0, mem_to_reg_m}, {31'd0, cur.mw});
          chk(cur.id, "pc_src_m",     {31'd0, pc_src_m},     {31'd0, cur.rw});
          chk(cur.id, "alu_result_m", {2'd0, alu_result_m},  {2'd0, cur.res});
          chk(cur.id, "write_data_m", {13'd0, write_data_m}, {13'd0, cur.res[REG_W-1:0]});
          chk(cur.id, "wa3_m",        {28'd0, wa3_m},        {28'd0, cur.res[RA_W-1:0]});
          chk(cur.id, "squash_count", {16'd0, squash_count}, {16'd0, cur.sq});
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, pending %0d", exp_q.size());
    mismatched++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "watchdog expired");
  end

  initial begin
    //   r  st fl v  cond  fw     af       res        rw mw  ec ck  eflags  ev erw emw eres       esq
    // reset wins over stall and flush
    step(1, 1, 1, 1, 4'hE, 2'b11, 4'b1111, 30'h123,   1, 1, -1, 1, 4'b0000, 0, 0, 0, 30'h0,     16'd0);
    // SUBS-like: sets Z
    step(0, 0, 0, 1, 4'hE, 2'b11, 4'b0100, 30'h0,     1, 0,  1, 1, 4'b0100, 1, 1, 0, 30'h0,     16'd0);
    // EQ passes on Z
    step(0, 0, 0, 1, 4'h0, 2'b00, 4'b0000, 30'h11,    1, 0,  1, 1, 4'b0100, 1, 1, 0, 30'h11,    16'd0);
    // NE fails: no side effects, no flag write, count 1
    step(0, 0, 0, 1, 4'h1, 2'b11, 4'b1111, 30'h22,    1, 1,  0, 1, 4'b0100, 0, 0, 0, 30'h22,    16'd1);
    // set N,V
    step(0, 0, 0, 1, 4'hE, 2'b11, 4'b1001, 30'h33,    0, 0,  1, 1, 4'b1001, 1, 0, 0, 30'h33,    16'd1);
    // GE with N==V passes
    step(0, 0, 0, 1, 4'hA, 2'b00, 4'b0000, 30'h44,    1, 0,  1, 1, 4'b1001, 1, 1, 0, 30'h44,    16'd1);
    // set 1101
    step(0, 0, 0, 1, 4'hE, 2'b11, 4'b1101, 30'h55,    0, 0,  1, 1, 4'b1101, 1, 0, 0, 30'h55,    16'd1);
    // GT fails on Z
    step(0, 0, 0, 1, 4'hC, 2'b11, 4'b0000, 30'h66,    1, 1,  0, 1, 4'b1101, 0, 0, 0, 30'h66,    16'd2);
    // NV never passes
    step(0, 0, 0, 1, 4'hF, 2'b00, 4'b0000, 30'h77,    1, 0,  0, 1, 4'b1101, 0, 0, 0, 30'h77,    16'd3);
    // invalid AL: cond passes combinationally but nothing happens
    step(0, 0, 0, 0, 4'hE, 2'b11, 4'b0000, 30'h88,    1, 1,  1, 1, 4'b1101, 0, 0, 0, 30'h88,    16'd3);
    // invalid NV: not counted
    step(0, 0, 0, 0, 4'hF, 2'b11, 4'b0000, 30'h99,    1, 0,  0, 1, 4'b1101, 0, 0, 0, 30'h99,    16'd3);
    // set 1111
    step(0, 0, 0, 1, 4'hE, 2'b11, 4'b1111, 30'hA0,    1, 0,  1, 1, 4'b1111, 1, 1, 0, 30'hA0,    16'd3);
    // partial write of N,Z only -> 0011
    step(0, 0, 0, 1, 4'hE, 2'b10, 4'b0000, 30'hB0,    1, 0,  1, 1, 4'b0011, 1, 1, 0, 30'hB0,    16'd3);
    // HI passes (C=1,Z=0), writes C,V only -> 0000
    step(0, 0, 0, 1, 4'h8, 2'b01, 4'b0000, 30'hB8,    0, 1,  1, 1, 4'b0000, 1, 0, 1, 30'hB8,    16'd3);
    // LT fails (N==V)
    step(0, 0, 0, 1, 4'hB, 2'b00, 4'b0000, 30'hC0,    1, 0,  0, 1, 4'b0000, 0, 0, 0, 30'hC0,    16'd4);
    // 3-cycle stall with flag-setting instruction: everything frozen
    for (int i = 0; i < 3; i++)
      step(0, 1, 0, 1, 4'hE, 2'b11, 4'b1000, 30'h3ABCD, 1, 0, 1, 1, 4'b0000, 0, 0, 0, 30'hC0, 16'd4);
    // releasing edge
    step(0, 0, 0, 1, 4'hE, 2'b11, 4'b1000, 30'h3ABCD, 1, 0,  1, 1, 4'b1000, 1, 1, 0, 30'h3ABCD, 16'd4);
    // flush over stall: bubble, flags hold
    step(0, 1, 1, 1, 4'hE, 2'b11, 4'b0101, 30'h12345, 1, 1,  1, 1, 4'b1000, 0, 0, 0, 30'h0,     16'd4);
    // flushed failing instruction is not counted
    step(0, 0, 1, 1, 4'hF, 2'b00, 4'b0000, 30'h1,     1, 0,  0, 1, 4'b1000, 0, 0, 0, 30'h0,     16'd4);
    // mid-stream reset under stall
    step(1, 1, 0, 1, 4'hE, 2'b11, 4'b1111, 30'h777,   1, 1,  1, 1, 4'b0000, 0, 0, 0, 30'h0,     16'd0);
    // drive the squash counter to all-ones
    for (int i = 0; i < 65535; i++)
      step(0, 0, 0, 1, 4'hF, 2'b11, 4'b1111, 30'hABC, 1, 1, 0, (i == 65534), 4'b0000, 0, 0, 0, 30'hABC, 16'hFFFF);
    // one more failure: saturates
    step(0, 0, 0, 1, 4'hF, 2'b11, 4'b1111, 30'hABD,   1, 1,  0, 1, 4'b0000, 0, 0, 0, 30'hABD,   16'hFFFF);
    // a passing instruction after saturation
    step(0, 0, 0, 1, 4'hE, 2'b00, 4'b0000, 30'h5,     1, 0,  1, 1, 4'b0000, 1, 1, 0, 30'h5,     16'hFFFF);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
